// File: rtl/uart2_rx.sv
// 8N1 UART receiver, 16x oversampled on the shared b_tick strobe, mid-bit sampling.
// Optional stop-bit check and frame_err pulse: define UART2_RX_FRAME_ERR_EN.
module uart2_rx (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_b_tick,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_done,
   output logic       o_rx_busy,
   output logic       o_frame_err
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t     r_state, w_state_nxt;
   logic       r_sync1, r_rx_s;
   logic [3:0] r_tick_cnt, w_tick_nxt;
   logic [2:0] r_bit_cnt, w_bit_nxt;
   logic [7:0] r_shreg, w_shreg_nxt;
   logic [7:0] r_rx_data, w_data_nxt;
   logic       r_rx_done, w_done_nxt;
   logic       r_frame_err, w_ferr_nxt;
   logic       w_stop_ok;

   // Without the frame check every stop sample is treated as good.
`ifdef UART2_RX_FRAME_ERR_EN
   assign w_stop_ok = r_rx_s;
`else
   assign w_stop_ok = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_rx_s  <= r_sync1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_tick_cnt  <= 4'd0;
         r_bit_cnt   <= 3'd0;
         r_shreg     <= 8'h00;
         r_rx_data   <= 8'h00;
         r_rx_done   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tick_cnt  <= w_tick_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_shreg     <= w_shreg_nxt;
         r_rx_data   <= w_data_nxt;
         r_rx_done   <= w_done_nxt;
         r_frame_err <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shreg_nxt = r_shreg;
      w_data_nxt  = r_rx_data;
      w_done_nxt  = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = START;
               w_tick_nxt  = 4'd0;
            end
         end
         // Tick 7 of the start bit is its centre; a high line there is a glitch.
         START: begin
            if (i_b_tick) begin
               if (r_tick_cnt == 4'd7) begin
                  if (!r_rx_s) begin
                     w_state_nxt = DATA;
                     w_tick_nxt  = 4'd0;
                     w_bit_nxt   = 3'd0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (i_b_tick) begin
               if (r_tick_cnt == 4'd15) begin
                  w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
                  w_tick_nxt  = 4'd0;
                  if (r_bit_cnt == 3'd7) begin
                     w_state_nxt = STOP;
                  end else begin
                     w_bit_nxt = r_bit_cnt + 3'd1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 4'd1;
               end
            end
         end
         // Leaving at mid-stop lets a following start edge be caught without a gap.
         STOP: begin
            if (i_b_tick) begin
               if (r_tick_cnt == 4'd15) begin
                  w_state_nxt = IDLE;
                  if (w_stop_ok) begin
                     w_data_nxt = r_shreg;
                     w_done_nxt = 1'b1;
                  end else begin
                     w_ferr_nxt = 1'b1;
                  end
               end else begin
                  w_tick_nxt = r_tick_cnt + 4'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_rx_data   = r_rx_data;
   assign o_rx_done   = r_rx_done;
   assign o_rx_busy   = (r_state != IDLE);
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart2_rx.sv
// Self-checking bench for uart2_rx: serializes frames onto rx and scores received bytes.
// Bad-stop expectations follow UART2_RX_FRAME_ERR_EN.
module tb_uart2_rx;

   localparam int BIT_CLKS = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bTick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rxData;
   logic       rxDone;
   logic       rxBusy;
   logic       frameErr;

   int errors = 0;
   int checks = 0;
   int divCnt = 0;
   int tickCount = 0;
   int ferrCnt = 0;
   int pulseViol = 0;
   logic prevPulse = 1'b0;

   logic [7:0] expQ[$];
   logic [7:0] obsQ[$];
   int         obsTickQ[$];

   uart2_rx dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_b_tick    (bTick),
      .i_rx        (rx),
      .o_rx_data   (rxData),
      .o_rx_done   (rxDone),
      .o_rx_busy   (rxBusy),
      .o_frame_err (frameErr)
   );

   always #5 clk = ~clk;

   // One b_tick every 8 clk, driven on the falling edge.
   always @(negedge clk) begin
      if (divCnt == 7) begin
         divCnt = 0;
         bTick = 1'b1;
         tickCount++;
      end else begin
         divCnt++;
         bTick = 1'b0;
      end
   end

   // Monitor: records every rx_done byte and frame_err pulse, and flags pulse-shape violations.
   always @(posedge clk) begin
      #1;
      if (rxDone) begin
         obsQ.push_back(rxData);
         obsTickQ.push_back(tickCount);
         if (rxBusy) pulseViol++;
      end
      if (frameErr) begin
         ferrCnt++;
         if (rxBusy) pulseViol++;
      end
      if ((rxDone && frameErr) || ((rxDone || frameErr) && prevPulse)) pulseViol++;
      prevPulse = rxDone || frameErr;
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic sendFrame(input logic [7:0] d, input logic stopVal,
                            input int bitClks, input int stopClks);
      rx = 1'b0;
      repeat (bitClks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (bitClks) @(negedge clk);
      end
      rx = stopVal;
      repeat (stopClks) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 00", rxData); end
      checks++;
      if (rxDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", rxDone); end
      checks++;
      if (rxBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", rxBusy); end
      checks++;
      if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b, expected 0", frameErr); end
      rst = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_loopback(input logic [7:0] d);
      logic [7:0] got, exp;
      int ferrBefore;
      ferrBefore = ferrCnt;
      expQ.push_back(d);
      sendFrame(d, 1'b1, BIT_CLKS, BIT_CLKS);
      for (int k = 0; k < 400 && obsQ.size() < 1; k++) @(negedge clk);
      checks++;
      if (obsQ.size() != 1) begin
         errors++;
         $display("[TB] FAIL loopback_count: got %0d pulses, expected 1", obsQ.size());
         obsQ.delete(); obsTickQ.delete(); expQ.delete();
      end else begin
         got = obsQ.pop_front();
         void'(obsTickQ.pop_front());
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL loopback_data: got %h, expected %h", got, exp); end
      end
      checks++;
      if (rxData !== d) begin errors++; $display("[TB] FAIL loopback_hold: got %h, expected %h", rxData, d); end
      checks++;
      if (rxBusy !== 1'b0) begin errors++; $display("[TB] FAIL loopback_busy: got %b, expected 0", rxBusy); end
      checks++;
      if (ferrCnt != ferrBefore) begin errors++; $display("[TB] FAIL loopback_ferr: got %0d, expected %0d", ferrCnt, ferrBefore); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, exp;
      int t0, t1;
      expQ.push_back(8'h00);
      expQ.push_back(8'hFF);
      sendFrame(8'h00, 1'b1, BIT_CLKS, BIT_CLKS);
      sendFrame(8'hFF, 1'b1, BIT_CLKS, BIT_CLKS);
      for (int k = 0; k < 400 && obsQ.size() < 2; k++) @(negedge clk);
      checks++;
      if (obsQ.size() != 2) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d pulses, expected 2", obsQ.size());
         obsQ.delete(); obsTickQ.delete(); expQ.delete();
      end else begin
         t0 = obsTickQ.pop_front();
         t1 = obsTickQ.pop_front();
         for (int i = 0; i < 2; i++) begin
            got = obsQ.pop_front();
            exp = expQ.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h, expected %h", i, got, exp); end
         end
         checks++;
         if (t1 - t0 != 160) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d ticks, expected 160", t1 - t0); end
      end
      checks++;
      if (rxData !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_hold: got %h, expected ff", rxData); end
   endtask

   task automatic test_glitch();
      int ferrBefore;
      ferrBefore = ferrCnt;
      rx = 1'b0;
      repeat (32) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      checks++;
      if (obsQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL glitch_done: got %0d pulses, expected 0", obsQ.size());
         obsQ.delete(); obsTickQ.delete();
      end
      checks++;
      if (ferrCnt != ferrBefore) begin errors++; $display("[TB] FAIL glitch_ferr: got %0d, expected %0d", ferrCnt, ferrBefore); end
      checks++;
      if (rxData !== 8'hFF) begin errors++; $display("[TB] FAIL glitch_hold: got %h, expected ff", rxData); end
      checks++;
      if (rxBusy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy: got %b, expected 0", rxBusy); end
   endtask

   task automatic test_bad_stop();
      int ferrBefore;
      test_loopback(8'hA5);
      ferrBefore = ferrCnt;
      // Stop bit low for 12 ticks: well past its centre sample, then the line idles.
      sendFrame(8'h3C, 1'b0, BIT_CLKS, 96);
      repeat (300) @(negedge clk);
`ifdef UART2_RX_FRAME_ERR_EN
      checks++;
      if (obsQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL badstop_done: got %0d pulses, expected 0", obsQ.size());
         obsQ.delete(); obsTickQ.delete();
      end
      checks++;
      if (ferrCnt != ferrBefore + 1) begin errors++; $display("[TB] FAIL badstop_ferr: got %0d, expected %0d", ferrCnt, ferrBefore + 1); end
      checks++;
      if (rxData !== 8'hA5) begin errors++; $display("[TB] FAIL badstop_hold: got %h, expected a5", rxData); end
`else
      expQ.push_back(8'h3C);
      checks++;
      if (obsQ.size() != 1) begin
         errors++;
         $display("[TB] FAIL badstop_done: got %0d pulses, expected 1", obsQ.size());
         obsQ.delete(); obsTickQ.delete(); expQ.delete();
      end else begin
         void'(obsTickQ.pop_front());
         checks++;
         if (obsQ[0] !== expQ[0]) begin errors++; $display("[TB] FAIL badstop_data: got %h, expected %h", obsQ[0], expQ[0]); end
         void'(obsQ.pop_front());
         void'(expQ.pop_front());
      end
      checks++;
      if (ferrCnt != ferrBefore) begin errors++; $display("[TB] FAIL badstop_ferr: got %0d, expected %0d", ferrCnt, ferrBefore); end
      checks++;
      if (rxData !== 8'h3C) begin errors++; $display("[TB] FAIL badstop_hold: got %h, expected 3c", rxData); end
`endif
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'h5A;
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = d[4];
      repeat (BIT_CLKS / 2) @(negedge clk);
      checks++;
      if (rxBusy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy: got %b, expected 1", rxBusy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      // The paired transmitter shares this reset, so the line returns to idle.
      rx = 1'b1;
      checks++;
      if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h, expected 00", rxData); end
      checks++;
      if (rxBusy !== 1'b0 || rxDone !== 1'b0 || frameErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_flags: got busy=%b done=%b ferr=%b, expected 0 0 0", rxBusy, rxDone, frameErr);
      end
      repeat (5 * BIT_CLKS) @(negedge clk);
      checks++;
      if (obsQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL midrst_done: got %0d pulses, expected 0", obsQ.size());
         obsQ.delete(); obsTickQ.delete();
      end
      test_loopback(8'h81);
   endtask

   task automatic test_baud_skew();
      logic [7:0] got, exp;
      int ferrBefore;
      ferrBefore = ferrCnt;
      expQ.push_back(8'h55);
      sendFrame(8'h55, 1'b1, 132, 132);
      repeat (50) @(negedge clk);
      expQ.push_back(8'hAA);
      sendFrame(8'hAA, 1'b1, 124, 124);
      for (int k = 0; k < 400 && obsQ.size() < 2; k++) @(negedge clk);
      checks++;
      if (obsQ.size() != 2) begin
         errors++;
         $display("[TB] FAIL skew_count: got %0d pulses, expected 2", obsQ.size());
         obsQ.delete(); obsTickQ.delete(); expQ.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            got = obsQ.pop_front();
            void'(obsTickQ.pop_front());
            exp = expQ.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL skew_data%0d: got %h, expected %h", i, got, exp); end
         end
      end
      checks++;
      if (ferrCnt != ferrBefore) begin errors++; $display("[TB] FAIL skew_ferr: got %0d, expected %0d", ferrCnt, ferrBefore); end
   endtask

   task automatic test_pulse_shape();
      checks++;
      if (pulseViol != 0) begin errors++; $display("[TB] FAIL pulse_shape: got %0d violations, expected 0", pulseViol); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_loopback(8'hA5);
      test_back_to_back();
      test_glitch();
      test_bad_stop();
      test_reset_midframe();
      test_baud_skew();
      test_pulse_shape();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart2_rx.md
# uart2_rx

8N1 UART receiver, paired with the uart2_tx transmitter on the same baud-tick generator. It oversamples the serial line at 16× baud using the shared one-cycle `b_tick` strobe. It detects and qualifies start bits at mid-bit and shifts in 8 data bits LSB-first. It then checks the stop bit and presents the byte with a one-cycle `rx_done` strobe to downstream logic (command decoder / FIFO).

## Interface
- No parameters. Frame format is fixed at 8 data bits, no parity, 1 stop bit, 16 ticks per bit.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `b_tick`  input  1  oversample strobe, one `clk` wide, 16 per bit period.
- `rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  last correctly received byte; held until the next good frame.
- `rx_done`  output  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_busy`  output  1  high while a frame is being received (states START/DATA/STOP).
- `frame_err`  output  1  one-cycle pulse on a low stop bit (see Configuration).

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer resets to 1. All decisions use `rx_s`.
- **Counters:**
  - `tick_cnt`: 4 bits, counts `b_tick`s within a bit.
  - `bit_cnt`: 3 bits, counts data bits.
- **Shift register:** 8 bits. Each sample is loaded as `{rx_s, shreg[7:1]}`, so data arrives LSB-first.
- **States:** IDLE, START, DATA, STOP.
  - **IDLE:** `rx_busy`=0. When `rx_s`==0, go to START and set `tick_cnt`=0. No `b_tick` is required to leave IDLE.
  - **START:** on `b_tick`:
    - If `tick_cnt`==7 and `rx_s`==0: set `tick_cnt`=0, `bit_cnt`=0, go to DATA. This is the mid-start sample.
    - If `tick_cnt`==7 and `rx_s`==1: false start; return to IDLE with no outputs.
    - Otherwise: `tick_cnt`++.
  - **DATA:** on `b_tick`:
    - If `tick_cnt`==15: shift in `rx_s` and set `tick_cnt`=0. If `bit_cnt`==7, go to STOP; otherwise `bit_cnt`++.
    - Otherwise: `tick_cnt`++.
    - Because of the 7-tick start offset, every data sample lands at mid-bit.
  - **STOP:** on `b_tick`:
    - If `tick_cnt`==15: sample the stop bit and return to IDLE.
    - If `rx_s`==1: set `rx_data`=`shreg` and pulse `rx_done`.
    - If `rx_s`==0: handled per Configuration.
    - Otherwise: `tick_cnt`++.
- **Back-to-back frames:** returning to IDLE at mid-stop allows the next start edge to be accepted after half a stop bit. Consecutive frames therefore work with no gap.
- **`b_tick` and `rx` in the same cycle:** the FSM evaluates the `rx_s` value already registered in that cycle.

## Timing
- **Reset values:**
  - `rx_data`=8'h00, `rx_done`=0, `rx_busy`=0, `frame_err`=0.
  - State=IDLE, counters=0, shift register=0, synchronizer=1.
- **Reset mid-frame:** return to IDLE on the next edge. The partial byte is discarded, no `rx_done` is issued, and `rx_data` returns to 0.
- **Synchronizer latency:** the `rx` falling edge enters START 3 `clk` edges later (2 synchronizer flops plus the state register).
- **Frame latency:** `rx_done` is high in the `clk` cycle after the `b_tick` at which STOP has `tick_cnt`==15. Start-detect to `rx_done` is 7+1 + 8×16 + 16 = 152 `b_tick`s, plus up to 1 `clk`.
- **Busy window:** `rx_busy` rises together with entry to START and falls together with the `rx_done`/`frame_err` cycle.
- **Pulse widths:** `rx_done` and `frame_err` are exactly 1 `clk` wide, never both high, and never back-to-back.

## Configuration
- Macro: `UART2_RX_FRAME_ERR_EN`.
- **Defined:** a low stop-bit sample pulses `frame_err` for 1 cycle. `rx_done` is suppressed and `rx_data` keeps its previous value.
- **Undefined:**
  - `frame_err` is tied to 0.
  - The stop bit is not checked: `rx_data` is updated and `rx_done` pulses whatever the stop-bit level.
  - The port list is identical in both builds.

## Test plan
- **Loopback:** `uart2_tx` → `uart2_rx` sharing `b_tick` (1 tick per 8 `clk`), send 0xA5 → one `rx_done` pulse, `rx_data`=0xA5, `rx_busy` low afterwards.
- **Back-to-back:** 0x00 then 0xFF with no idle gap → two `rx_done` pulses 160 `b_tick`s apart; `rx_data`=0x00, then 0xFF.
- **Glitch rejection:** `rx` low for 4 `b_tick`s, then high → FSM returns to IDLE; no `rx_done`, no `frame_err`; `rx_data` unchanged.
- **Bad stop bit:** 0x3C framed with stop=0 and macro defined → `frame_err` pulse, no `rx_done`, `rx_data` keeps prior 0xA5. Same stimulus with macro undefined → `rx_done` pulse with `rx_data`=0x3C.
- **Reset mid-frame:** assert `rst` 1 cycle during bit 4 of 0x5A → all outputs 0 next cycle; the remainder of the frame produces no `rx_done`. A following 0x81 frame is received correctly.
- **Baud skew:** bench transmit rate +3% and −3% from the `b_tick` rate, 0x55 and 0xAA → both bytes received correctly with no `frame_err`.
